keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
- Drives a 4x4 active-low key matrix and debounces it.
- Produces the 5-bit Key bus consumed by the keypad pulse logic. Key[4] is the "key held" strobe and Key[3:0] is the key code.
- Upstream producer side of the Key interface: guarantees one clean rising edge of Key[4] per physical press, with a stable code while Key[4] is high.

Parameters:
SCAN_DIV, 1000, newClock cycles per column dwell (sample period); minimum 4
DEBOUNCE_CNT, 8, consecutive identical samples required to accept a press or a release; minimum 1
REPEAT_PERIOD, 250, sample periods between auto-repeat edges (used only with KEYPAD_REPEAT_EN)

Ports:
newClock  input  1  system clock
reset  input  1  asynchronous, active-high reset
Row  input  4  matrix row lines, active-low, externally pulled up
Col  output  4  matrix column drive, active-low, exactly one bit low at any time
Key  output  5  Key[4] = debounced key held; Key[3:0] = code, valid only while Key[4]=1, else 0

Behaviour:
- Reset (async, active-high): Col=4'b1110, Key=5'b00000, state=SCAN, all counters 0, synchronizer flops 4'b1111.
- Row passes through a 2-flop synchronizer; all decisions use the synchronized value.
- Sample point: last cycle of each SCAN_DIV dwell (divider count == SCAN_DIV-1). The divider free-runs and wraps SCAN_DIV-1 -> 0.
- Code = {col_idx[1:0], row_idx[1:0]}. col_idx is the position of the low bit in Col; row_idx is the position of the single low bit in synchronized Row.
- Valid single press: exactly one Row bit low. Zero or more than one low bit counts as "no press" (ghost rejection).
- States:
  - SCAN: at each sample point with no valid press, rotate Col left (1110->1101->1011->0111->1110). On a valid press, latch the code, hold Col, set stable_cnt=1, go to DEBOUNCE. If DEBOUNCE_CNT==1, go directly to HELD instead.
  - DEBOUNCE: Col held. Each sample point:
    - Same code: stable_cnt+1. When stable_cnt reaches DEBOUNCE_CNT, go to HELD and set Key<={1,code} on that same edge.
    - Different code or no press: stable_cnt=0, rotate Col, return to SCAN.
  - HELD: Col held, Key stable. Each sample point:
    - No press: rel_cnt+1.
    - Valid press with the same code: rel_cnt=0.
    - Different valid code: ignored, treated as still held, rel_cnt=0.
    - When rel_cnt reaches DEBOUNCE_CNT: Key<=0, rotate Col, go to SCAN.
- Latency: Key[4] rises at the DEBOUNCE_CNT-th consecutive matching sample point after the press is first seen. Key[4] falls at the DEBOUNCE_CNT-th consecutive empty sample point.
- Key changes only on sample-point edges (plus the repeat gap in the optional feature). Key[3:0] never changes while Key[4]=1.
- Reset mid-press: outputs clear immediately. After release of reset, a still-held key is re-detected from SCAN and produces a fresh rising edge.
- Counter widths are $clog2 of the parameter plus 1. Counters saturate and never wrap.

Optional Feature:
KEYPAD_REPEAT_EN
- Defined: in HELD, a repeat counter advances once per sample point. On reaching REPEAT_PERIOD, Key[4] is driven 0 for exactly one newClock cycle, then returns to 1 with the same code, and the counter clears. This gives the downstream edge detector a new press event. A release resets the repeat counter.
- Not defined: repeat logic is absent and Key[4] stays high for the whole hold.

Test Plan (SCAN_DIV=4, DEBOUNCE_CNT=3, REPEAT_PERIOD=5):
- Reset asserted for 3 cycles, Row=4'b1111 -> Key=0; Col cycles 1110,1101,1011,0111 changing every 4 cycles.
- Clean press at column 2, row 1 (Row=4'b1101 while Col=4'b1011) -> Key=5'b11001 at the 3rd matching sample, about 8 cycles after first detection. Key returns to 0 three empty samples after release.
- Bounce: Row toggles 1101/1111 on alternate sample points, then stays 1101 -> no Key[4] rise until 3 consecutive matches; exactly one rising edge.
- Ghost: Row=4'b1001 in any column -> Key stays 0 and Col keeps rotating.
- Reset asserted while Key=5'b11001 and the key is still pressed -> Key=0 within the same cycle. After reset release, Key rises again to 5'b11001.
- With KEYPAD_REPEAT_EN and a key held 20 sample points after acceptance -> Key[4] shows four 1-cycle low gaps, code constant at 4'b1001.

Source files
------------

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low key matrix, debounces one key at a time, drives Key[4:0].
// Optional macro KEYPAD_REPEAT_EN adds auto-repeat by dropping Key[4] for one cycle per period.
module keypad_scanner #(
   parameter int SCAN_DIV      = 1000,
   parameter int DEBOUNCE_CNT  = 8,
   parameter int REPEAT_PERIOD = 250
) (
   input  logic       newClock,
   input  logic       reset,
   input  logic [3:0] Row,
   output logic [3:0] Col,
   output logic [4:0] Key
);

   localparam int DIV_W = $clog2(SCAN_DIV) + 1;
   localparam int CNT_W = $clog2(DEBOUNCE_CNT) + 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0] DEB_MAX  = CNT_W'(DEBOUNCE_CNT);

   // Out-of-range parameters show up as g_bad_params in the elaborated hierarchy.
   if (SCAN_DIV < 4 || DEBOUNCE_CNT < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
   end

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      DEBOUNCE = 2'd1,
      HELD     = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic [DIV_W-1:0] div_cnt;
   logic [3:0]       row_p0, row_p1;
   logic [3:0]       col_cur, col_nxt;
   logic [4:0]       key_cur, key_nxt;
   logic [3:0]       code, code_nxt;
   logic [CNT_W-1:0] stable_cnt, stable_nxt, stable_inc;
   logic [CNT_W-1:0] rel_cnt, rel_nxt, rel_inc;
   logic             sample;
   logic             row_ok;
   logic [1:0]       row_idx;
   logic [1:0]       col_idx;
   logic [3:0]       cur_code;

`ifdef KEYPAD_REPEAT_EN
   localparam int REP_W = $clog2(REPEAT_PERIOD) + 1;
   localparam logic [REP_W-1:0] REP_MAX = REP_W'(REPEAT_PERIOD);
   logic [REP_W-1:0] rep_cnt, rep_nxt, rep_inc;
   logic             gap, gap_nxt;

   function automatic logic [REP_W-1:0] sat_inc_rep(input logic [REP_W-1:0] v);
      return (&v) ? v : v + REP_W'(1);
   endfunction
`endif

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   function automatic logic [3:0] rotl(input logic [3:0] c);
      return {c[2:0], c[3]};
   endfunction

   // Stage p0/p1: two-flop synchronizer on the asynchronous row lines
   always_ff @(posedge newClock or posedge reset) begin
      if (reset) begin
         row_p0 <= 4'b1111;
         row_p1 <= 4'b1111;
      end else begin
         row_p0 <= Row;
         row_p1 <= row_p0;
      end
   end

   assign sample = (div_cnt == DIV_LAST);

   // Anything other than exactly one low row is treated as no press (ghost rejection).
   always_comb begin
      row_ok  = 1'b1;
      row_idx = 2'd0;
      case (row_p1)
         4'b1110: row_idx = 2'd0;
         4'b1101: row_idx = 2'd1;
         4'b1011: row_idx = 2'd2;
         4'b0111: row_idx = 2'd3;
         default: row_ok  = 1'b0;
      endcase
   end

   always_comb begin
      col_idx = 2'd0;
      case (col_cur)
         4'b1101: col_idx = 2'd1;
         4'b1011: col_idx = 2'd2;
         4'b0111: col_idx = 2'd3;
         default: col_idx = 2'd0;
      endcase
   end

   assign cur_code   = {col_idx, row_idx};
   assign stable_inc = sat_inc(stable_cnt);
   assign rel_inc    = sat_inc(rel_cnt);
`ifdef KEYPAD_REPEAT_EN
   assign rep_inc    = sat_inc_rep(rep_cnt);
`endif

   always_comb begin
      state_nxt  = state;
      col_nxt    = col_cur;
      key_nxt    = key_cur;
      code_nxt   = code;
      stable_nxt = stable_cnt;
      rel_nxt    = rel_cnt;
`ifdef KEYPAD_REPEAT_EN
      rep_nxt    = rep_cnt;
      gap_nxt    = 1'b0;
      if (gap) begin
         key_nxt = {1'b1, code};
      end
`endif
      if (sample) begin
         case (state)
            SCAN: begin
               if (row_ok) begin
                  code_nxt   = cur_code;
                  stable_nxt = CNT_W'(1);
                  if (DEBOUNCE_CNT == 1) begin
                     state_nxt = HELD;
                     key_nxt   = {1'b1, cur_code};
                     rel_nxt   = '0;
`ifdef KEYPAD_REPEAT_EN
                     rep_nxt   = '0;
`endif
                  end else begin
                     state_nxt = DEBOUNCE;
                  end
               end else begin
                  col_nxt = rotl(col_cur);
               end
            end
            DEBOUNCE: begin
               if (row_ok && (cur_code == code)) begin
                  stable_nxt = stable_inc;
                  if (stable_inc >= DEB_MAX) begin
                     state_nxt = HELD;
                     key_nxt   = {1'b1, code};
                     rel_nxt   = '0;
`ifdef KEYPAD_REPEAT_EN
                     rep_nxt   = '0;
`endif
                  end
               end else begin
                  stable_nxt = '0;
                  col_nxt    = rotl(col_cur);
                  state_nxt  = SCAN;
               end
            end
            HELD: begin
               // A different valid code still counts as held; only empty samples release.
               if (!row_ok && (rel_inc >= DEB_MAX)) begin
                  key_nxt    = 5'b00000;
                  col_nxt    = rotl(col_cur);
                  state_nxt  = SCAN;
                  rel_nxt    = '0;
                  stable_nxt = '0;
`ifdef KEYPAD_REPEAT_EN
                  rep_nxt    = '0;
`endif
               end else begin
                  rel_nxt = row_ok ? '0 : rel_inc;
`ifdef KEYPAD_REPEAT_EN
                  if (rep_inc >= REP_MAX) begin
                     rep_nxt = '0;
                     key_nxt = 5'b00000;
                     gap_nxt = 1'b1;
                  end else begin
                     rep_nxt = rep_inc;
                  end
`endif
               end
            end
            default: state_nxt = SCAN;
         endcase
      end
   end

   // Control state: divider, FSM, column drive, counters and the Key register
   always_ff @(posedge newClock or posedge reset) begin
      if (reset) begin
         state      <= SCAN;
         div_cnt    <= '0;
         col_cur    <= 4'b1110;
         key_cur    <= 5'b00000;
         stable_cnt <= '0;
         rel_cnt    <= '0;
`ifdef KEYPAD_REPEAT_EN
         rep_cnt    <= '0;
         gap        <= 1'b0;
`endif
      end else begin
         state      <= state_nxt;
         div_cnt    <= sample ? '0 : div_cnt + DIV_W'(1);
         col_cur    <= col_nxt;
         key_cur    <= key_nxt;
         stable_cnt <= stable_nxt;
         rel_cnt    <= rel_nxt;
`ifdef KEYPAD_REPEAT_EN
         rep_cnt    <= rep_nxt;
         gap        <= gap_nxt;
`endif
      end
   end

   // Latched code is pure data; it is only read after SCAN has written it.
   always_ff @(posedge newClock) begin
      code <= code_nxt;
   end

   assign Col = col_cur;
   assign Key = key_cur;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: drives a modelled 4x4 key matrix and checks Col/Key every cycle against a
// sample-point model of the scanning rules, plus hand-computed latency and value checks.
`timescale 1ns/1ps
module tb_keypad_scanner;

   localparam int SCAN_DIV = 4;
   localparam int DEB      = 3;
   localparam int REP      = 5;

   logic        newClock = 1'b0;
   logic        reset    = 1'b1;
   logic [15:0] keys     = 16'h0000;
   logic [3:0]  Row;
   logic [3:0]  Col;
   logic [4:0]  Key;

   int total = 0;
   int bad   = 0;
   int rises = 0;

   keypad_scanner #(
      .SCAN_DIV(SCAN_DIV),
      .DEBOUNCE_CNT(DEB),
      .REPEAT_PERIOD(REP)
   ) dut (
      .newClock(newClock),
      .reset(reset),
      .Row(Row),
      .Col(Col),
      .Key(Key)
   );

   always #5 newClock = ~newClock;

   // Key (c,r) is bit c*4+r; it pulls row r low while column c is driven low.
   always_comb begin
      Row = 4'b1111;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            if (keys[c*4+r] && !Col[c]) Row[r] = 1'b0;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: mode 0 scanning, 1 confirming, 2 held; m_run counts consecutive samples.
   int         m_div, m_col, m_mode, m_run, m_code, m_rep;
   bit         m_gap;
   logic [4:0] m_key;
   logic [3:0] m_s1, m_s2;
   logic [3:0] row_cap = 4'b1111;

   task automatic model_reset();
      m_div = 0; m_col = 0; m_mode = 0; m_run = 0; m_code = 0; m_rep = 0;
      m_gap = 0; m_key = 5'b0; m_s1 = 4'hF; m_s2 = 4'hF;
   endtask

   task automatic model_step();
      bit is_sample, single;
      int row, code;
      is_sample = (m_div == SCAN_DIV - 1);
      single    = ($countones(~m_s2) == 1);
      row = 0;
      for (int r = 0; r < 4; r++) if (!m_s2[r]) row = r;
      code = m_col * 4 + row;
      if (m_gap) begin
         m_key = {1'b1, 4'(m_code)};
         m_gap = 0;
      end
      if (is_sample) begin
         if (m_mode == 0) begin
            if (single) begin
               m_code = code; m_run = 1; m_mode = 1;
            end else m_col = (m_col + 1) % 4;
         end else if (m_mode == 1) begin
            if (single && code == m_code) begin
               m_run++;
               if (m_run == DEB) begin
                  m_mode = 2; m_run = 0; m_rep = 0; m_key = {1'b1, 4'(m_code)};
               end
            end else begin
               m_mode = 0; m_run = 0; m_col = (m_col + 1) % 4;
            end
         end else begin
            if (single) m_run = 0; else m_run++;
            if (m_run == DEB) begin
               m_mode = 0; m_run = 0; m_rep = 0; m_key = 5'b0; m_col = (m_col + 1) % 4;
            end
`ifdef KEYPAD_REPEAT_EN
            else begin
               m_rep++;
               if (m_rep == REP) begin
                  m_rep = 0; m_key = 5'b0; m_gap = 1;
               end
            end
`endif
         end
      end
      m_s2  = m_s1;
      m_s1  = row_cap;
      m_div = (m_div + 1) % SCAN_DIV;
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge newClock or posedge reset);
         if (reset) model_reset();
         else model_step();
      end
   end

   initial begin
      logic [3:0] ce;
      forever begin
         @(negedge newClock);
         ce = ~(4'b0001 << m_col);
         check("col_model", {28'h0, Col}, {28'h0, ce});
         check("key_model", {27'h0, Key}, {27'h0, m_key});
         row_cap = Row;
      end
   end

   initial begin
      forever begin
         @(posedge Key[4]);
         rises++;
      end
   end

   task automatic tick();
      @(posedge newClock);
      #1;
   endtask

   task automatic wait_key(input logic level, input int limit, output int n);
      n = 0;
      while (Key[4] !== level && n < limit) begin
         tick();
         n++;
      end
   endtask

   initial begin
      int n, r0, changes, lows;
      logic [3:0] prev_col;
      logic [3:0] col_exp [5];
      int         col_k   [5];
      bit         code_ok;
      col_exp = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
      col_k   = '{3, 4, 8, 12, 16};

      reset = 1'b1;
      keys  = 16'h0000;
      repeat (3) tick();
      check("reset_key", {27'h0, Key}, 32'h0);
      check("reset_col", {28'h0, Col}, 32'hE);
      reset = 1'b0;

      // Column walk after reset: rotation on every 4th edge.
      for (int k = 1; k <= 16; k++) begin
         tick();
         for (int i = 0; i < 5; i++)
            if (col_k[i] == k) check("col_walk", {28'h0, Col}, {28'h0, col_exp[i]});
      end

      // Clean press at column 2, row 1, applied right after column 2 becomes active.
      n = 0;
      while (Col !== 4'b1011 && n < 40) begin
         tick();
         n++;
      end
      check("wait_col2", {31'h0, Col === 4'b1011}, 32'h1);
      r0 = rises;
      keys = 16'h0200;
      wait_key(1'b1, 40, n);
      check("press_latency", n, 12);
      check("press_key", {27'h0, Key}, 32'h19);
      repeat (8) tick();
      check("hold_key", {27'h0, Key}, 32'h19);
      keys = 16'h0000;
      wait_key(1'b0, 40, n);
      check("release_latency", n, 12);
      check("release_key", {27'h0, Key}, 32'h0);
      check("clean_rises", rises - r0, 1);

      // Bounce: key toggles every sample period, then stays down.
      r0 = rises;
      for (int j = 0; j < 8; j++) begin
         keys = (j % 2 == 0) ? 16'h0200 : 16'h0000;
         repeat (4) tick();
      end
      check("bounce_no_rise", rises - r0, 0);
      keys = 16'h0200;
      wait_key(1'b1, 80, n);
      check("bounce_key", {27'h0, Key}, 32'h19);
      check("bounce_rises", rises - r0, 1);
      keys = 16'h0000;
      wait_key(1'b0, 40, n);
      check("bounce_release", {27'h0, Key}, 32'h0);

      // Ghost: rows 1 and 2 low in every column.
      r0 = rises;
      keys = 16'h6666;
      changes = 0;
      prev_col = Col;
      repeat (40) begin
         tick();
         if (Col !== prev_col) changes++;
         prev_col = Col;
      end
      check("ghost_rotations", changes, 10);
      check("ghost_key", {27'h0, Key}, 32'h0);
      check("ghost_rises", rises - r0, 0);
      keys = 16'h0000;
      repeat (8) tick();

      // Reset while the key is held and still pressed.
      r0 = rises;
      keys = 16'h0200;
      wait_key(1'b1, 80, n);
      check("pre_reset_key", {27'h0, Key}, 32'h19);
      reset = 1'b1;
      #1;
      check("midreset_key", {27'h0, Key}, 32'h0);
      check("midreset_col", {28'h0, Col}, 32'hE);
      repeat (2) tick();
      reset = 1'b0;
      wait_key(1'b1, 80, n);
      check("post_reset_key", {27'h0, Key}, 32'h19);
      check("post_reset_rises", rises - r0, 2);

`ifdef KEYPAD_REPEAT_EN
      lows = 0;
      code_ok = 1'b1;
      repeat (80) begin
         tick();
         if (Key[4] === 1'b0) lows++;
         else if (Key[3:0] !== 4'b1001) code_ok = 1'b0;
      end
      check("repeat_gaps", lows, 4);
      check("repeat_code", {31'h0, code_ok}, 32'h1);
`else
      lows = 0;
      code_ok = 1'b1;
      repeat (80) begin
         tick();
         if (Key !== 5'b11001) code_ok = 1'b0;
      end
      check("hold_steady", {31'h0, code_ok}, 32'h1);
`endif
      keys = 16'h0000;
      wait_key(1'b0, 40, n);
      check("final_release", {27'h0, Key}, 32'h0);
      repeat (4) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
